// File: rtl/wb_trace_checker.sv
// wb_trace_checker: sequences core reset, then checks MEM/WB
// register writes against a preloaded expected trace.
module wb_trace_checker #(
  parameter int DATA_W       = 8,
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_CHECKS   = 8,
  parameter int IDX_W        = 3,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  PC_reset,
  input  logic                  start,
  input  logic                  exp_we,
  input  logic [IDX_W-1:0]      exp_idx,
  input  logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0]     exp_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [IDX_W-1:0]      err_idx,
  output logic [DATA_W-1:0]     err_data,
  output logic [IDX_W:0]        match_count,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int HC_W = (RESET_CYCLES > 1) ?
                        $clog2(RESET_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST =
    HC_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W:0] FULL =
    (IDX_W+1)'(NUM_CHECKS);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, HOLD_RST, RUN, PASS, FAIL
  } state_t;

  state_t state, state_n;

  logic [REG_ADDR_W-1:0] tab_addr [NUM_CHECKS];
  logic [DATA_W-1:0]     tab_data [NUM_CHECKS];

  logic [HC_W-1:0]   hcnt, hcnt_n;
  logic              core_rst_n, busy_n, done_n, pass_n;
  logic [1:0]        code_n;
  logic [IDX_W-1:0]  err_idx_n, ptr;
  logic [DATA_W-1:0] err_data_n;
  logic [IDX_W:0]    mc_n, mc_inc;
  logic [CNT_W-1:0]  cyc_n;
  logic              qual, hit, miss, fin, tmo, tab_open;

  assign ptr      = match_count[IDX_W-1:0];
  assign mc_inc   = match_count + 1'b1;
  assign qual     = wb_valid && (wb_addr != '0);
  assign hit      = qual &&
                    (tab_addr[ptr] == wb_addr) &&
                    (tab_data[ptr] == wb_data);
  assign miss     = qual && !hit;
  assign fin      = hit && (mc_inc == FULL);
  assign tmo      = (cycle_count == TMO_LAST);
  assign tab_open = (state == IDLE) ||
                    (state == PASS) ||
                    (state == FAIL);

  // Expected trace table; survives PC_reset on purpose.
  always_ff @(posedge clk) begin
    if (exp_we && tab_open &&
        (32'(exp_idx) < NUM_CHECKS)) begin
      tab_addr[exp_idx] <= exp_addr;
      tab_data[exp_idx] <= exp_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (PC_reset) begin
      state       <= IDLE;
      hcnt        <= '0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= 2'd0;
      err_idx     <= '0;
      err_data    <= '0;
      match_count <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      hcnt        <= hcnt_n;
      core_rst    <= core_rst_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      fail_code   <= code_n;
      err_idx     <= err_idx_n;
      err_data    <= err_data_n;
      match_count <= mc_n;
      cycle_count <= cyc_n;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    core_rst_n = core_rst;
    busy_n     = busy;
    done_n     = done;
    pass_n     = pass;
    code_n     = fail_code;
    err_idx_n  = err_idx;
    err_data_n = err_data;
    mc_n       = match_count;
    cyc_n      = cycle_count;
    unique case (state)
      IDLE, PASS, FAIL: begin
        if (start) begin
          state_n    = HOLD_RST;
          hcnt_n     = '0;
          core_rst_n = 1'b1;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          pass_n     = 1'b0;
          code_n     = 2'd0;
          err_idx_n  = '0;
          err_data_n = '0;
          mc_n       = '0;
          cyc_n      = '0;
        end
      end
      HOLD_RST: begin
        if (hcnt == HC_LAST) begin
          state_n    = RUN;
          core_rst_n = 1'b0;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      RUN: begin
        if (cycle_count != '1) cyc_n = cycle_count + 1'b1;
        if (hit) mc_n = mc_inc;
        if (fin) begin
          state_n = PASS;
          pass_n  = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else if (miss) begin
          state_n    = FAIL;
          code_n     = 2'd1;
          err_idx_n  = ptr;
          err_data_n = wb_data;
          done_n     = 1'b1;
          busy_n     = 1'b0;
        end else if (tmo) begin
          state_n   = FAIL;
          code_n    = 2'd2;
          err_idx_n = mc_n[IDX_W-1:0];
          done_n    = 1'b1;
          busy_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: randomized and directed trace runs
// checked against a trace-scanning reference model.
module tb_wb_trace_checker;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int RC = 2;
  localparam int TO = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          PC_reset = 1'b1;
  logic          start = 1'b0;
  logic          exp_we = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          core_rst, busy, done, pass;
  logic [1:0]    fail_code;
  logic [IW-1:0] err_idx;
  logic [DW-1:0] err_data;
  logic [IW:0]   match_count;
  logic [CW-1:0] cycle_count;

  wb_trace_checker #(
    .DATA_W(DW), .REG_ADDR_W(AW), .NUM_CHECKS(N),
    .IDX_W(IW), .RESET_CYCLES(RC), .TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .PC_reset(PC_reset), .start(start),
    .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .core_rst(core_rst),
    .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .err_idx(err_idx),
    .err_data(err_data), .match_count(match_count),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int ta [N];
  int td [N];
  int sv [128];
  int sa [128];
  int sd [128];
  int len;

  int e_pass, e_code, e_idx, e_data, e_mc, e_cyc, e_dec;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h",
               tag, got, exp);
    end
  endtask

  task automatic load(input int a [N], input int d [N]);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      exp_we = 1'b1;
      exp_idx = IW'(i);
      exp_addr = AW'(a[i]);
      exp_data = DW'(d[i]);
      ta[i] = a[i];
      td[i] = d[i];
    end
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  // Scan the RUN-cycle stream: first outcome wins, with
  // final match > mismatch > timeout on the same cycle.
  task automatic model();
    int m;
    int v, a, d;
    m = 0;
    e_dec = -1;
    for (int i = 0; i < TO; i++) begin
      v = (i < len) ? sv[i] : 0;
      a = sa[i];
      d = sd[i];
      if (v != 0 && a != 0) begin
        if (a == ta[m] && d == td[m]) begin
          m++;
          if (m == N) begin
            e_pass = 1; e_code = 0; e_idx = 0;
            e_data = 0; e_mc = m; e_cyc = i + 1;
            e_dec = i;
            return;
          end
        end else begin
          e_pass = 0; e_code = 1; e_idx = m;
          e_data = d; e_mc = m; e_cyc = i + 1;
          e_dec = i;
          return;
        end
      end
      if (i == TO - 1) begin
        e_pass = 0; e_code = 2; e_idx = m;
        e_data = 0; e_mc = m; e_cyc = TO;
        e_dec = i;
      end
    end
  endtask

  task automatic put(input int i, input int v,
                     input int a, input int d);
    sv[i] = v;
    sa[i] = a;
    sd[i] = d;
  endtask

  task automatic good_stream();
    len = N;
    for (int i = 0; i < N; i++) put(i, 1, ta[i], td[i]);
  endtask

  task automatic pulse_start(input string nm);
    int hi;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi = 0;
    while (core_rst && hi < 10) begin
      hi++;
      @(negedge clk);
    end
    chk({nm, "_rst_len"}, hi, RC);
    chk({nm, "_busy"}, busy, 1);
  endtask

  task automatic go(input string nm, input int poke_at);
    int w;
    model();
    pulse_start(nm);
    for (int i = 0; i < len; i++) begin
      wb_valid = sv[i][0];
      wb_addr = AW'(sa[i]);
      wb_data = DW'(sd[i]);
      if (i == poke_at) begin
        exp_we = 1'b1;
        exp_idx = '0;
        exp_addr = 5'd9;
        exp_data = 8'h99;
        start = 1'b1;
      end
      @(negedge clk);
      exp_we = 1'b0;
      start = 1'b0;
      if (i == e_dec) chk({nm, "_latency"}, done, 1);
    end
    wb_valid = 1'b0;
    w = 0;
    while (!done && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!done) chk({nm, "_done_wait"}, 0, 1);
    repeat (2) @(negedge clk);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy0"}, busy, 0);
    chk({nm, "_core_rst"}, core_rst, 0);
    chk({nm, "_pass"}, pass, e_pass);
    chk({nm, "_code"}, fail_code, e_code);
    chk({nm, "_err_idx"}, err_idx, e_idx);
    chk({nm, "_err_data"}, err_data, e_data);
    chk({nm, "_mc"}, match_count, e_mc);
    chk({nm, "_cyc"}, cycle_count, e_cyc);
  endtask

  initial begin
    int a [N];
    int d [N];
    int k, r;

    repeat (2) @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_mc", match_count, 0);
    chk("rst_cyc", cycle_count, 0);
    PC_reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      a[i] = i + 1;
      d[i] = i + 1;
    end
    load(a, d);

    good_stream();
    go("basic", -1);

    good_stream();
    len = 12;
    for (int i = N; i < 12; i++) put(i, 1, 4, i);
    put(2, 1, 3, 'h55);
    go("mismatch", -1);

    len = 5;
    for (int i = 0; i < 5; i++) put(i, 1, ta[i], td[i]);
    go("timeout", -1);

    len = TO;
    for (int i = 0; i < TO; i++) put(i, 0, 0, 0);
    for (int i = 0; i < N - 1; i++) put(i, 1, ta[i], td[i]);
    put(TO - 1, 1, ta[N-1], td[N-1]);
    go("tmo_prio", -1);

    len = 2 * N;
    for (int i = 0; i < N; i++) begin
      put(2 * i, 1, ta[i], td[i]);
      put(2 * i + 1, 1, 0, 'hFF);
    end
    go("r0_skip", -1);

    pulse_start("abort");
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1;
      wb_addr = AW'(ta[i]);
      wb_data = DW'(td[i]);
      @(negedge clk);
    end
    wb_valid = 1'b0;
    chk("abort_mc4", match_count, 4);
    PC_reset = 1'b1;
    @(negedge clk);
    PC_reset = 1'b0;
    chk("abort_core_rst", core_rst, 1);
    chk("abort_mc", match_count, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    good_stream();
    go("rerun", -1);

    good_stream();
    go("poke", 2);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = $urandom_range(31, 1);
        d[i] = $urandom_range(255, 0);
      end
      load(a, d);
      len = $urandom_range(40, 4);
      k = 0;
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(99, 0);
        if (r < 60 && k < N) begin
          put(i, 1, ta[k], td[k]);
          k++;
        end else if (r < 80) begin
          put(i, 0, $urandom_range(31, 0),
              $urandom_range(255, 0));
        end else if (r < 93) begin
          put(i, 1, 0, $urandom_range(255, 0));
        end else begin
          put(i, 1, $urandom_range(31, 1),
              $urandom_range(255, 0));
        end
      end
      go($sformatf("rnd%0d", n), -1);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
